simultaneous_to_sequential_reg_ps_first: RTL

SIMULTANEOUS_TO_SEQUENTIAL_REG_PS_FIRST -- requirements
Module: simultaneous_to_sequential_reg_ps_first

---
 rtl/simultaneous_to_sequential_reg_ps_first_pkg.sv | 15 +
 rtl/simultaneous_to_sequential_reg_ps_first_reg.sv | 36 +++
 rtl/simultaneous_to_sequential_reg_ps_first.sv | 123 ++++++++++++
 3 files changed

// File: rtl/simultaneous_to_sequential_reg_ps_first_pkg.sv
// Shared definitions for the parallel-to-serial converter: FSM encoding and
// beat-counter sizing.
package simultaneous_to_sequential_reg_ps_first_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter must reach SHIFT_LEN-1 and still have headroom for the compare.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/simultaneous_to_sequential_reg_ps_first_reg.sv
// Loadable slice shift register: parallel load, shift toward slice 0 on
// enable, zero fill from the top.
module simultaneous_to_sequential_reg #(
  parameter int DEPTH     = 3,
  parameter int BIT_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       en,
  input  logic [DEPTH*BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0]       head
);

  logic [DEPTH-1:0][BIT_WIDTH-1:0] q;
  logic [DEPTH-1:0][BIT_WIDTH-1:0] shifted;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    if (i == DEPTH - 1) begin : g_top
      assign shifted[i] = '0;
    end else begin : g_mid
      assign shifted[i] = q[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= d;
    else if (en)   q <= shifted;
  end

  assign head = q[0];

endmodule

// File: rtl/simultaneous_to_sequential_reg_ps_first.sv
// Parallel word to serial beats; the first beat passes through combinationally,
// the remaining slices are replayed from a holding register.
module simultaneous_to_sequential_reg_ps_first
  import simultaneous_to_sequential_reg_ps_first_pkg::*;
#(
  parameter int DIRECTION = 1,
  parameter int SHIFT_LEN = 4,
  parameter int BIT_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           in_ctr_Arst_n,
  input  logic                           in_ctr_Srst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BIT_WIDTH-1:0]           out,
  output logic                           out_last
);

  localparam int CW    = cnt_width(SHIFT_LEN);
  localparam int DEPTH = (SHIFT_LEN > 1) ? SHIFT_LEN - 1 : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SHIFT_LEN - 1);

  state_e                     state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic                       load, en;
  logic [DEPTH*BIT_WIDTH-1:0] load_d;
  logic [BIT_WIDTH-1:0]       first_slice, head;

  // Holding register is ordered so that slice 0 is always the next beat.
  if (DIRECTION > 0) begin : g_hi_first
    assign first_slice = in[BIT_WIDTH*(SHIFT_LEN-1) +: BIT_WIDTH];
  end else begin : g_lo_first
    assign first_slice = in[0 +: BIT_WIDTH];
  end

  if (SHIFT_LEN == 1) begin : g_single
    assign load_d = '0;
  end else begin : g_multi
    for (genvar j = 0; j < DEPTH; j++) begin : g_ld
      if (DIRECTION > 0) begin : g_desc
        assign load_d[BIT_WIDTH*j +: BIT_WIDTH] = in[BIT_WIDTH*(SHIFT_LEN-2-j) +: BIT_WIDTH];
      end else begin : g_asc
        assign load_d[BIT_WIDTH*j +: BIT_WIDTH] = in[BIT_WIDTH*(j+1) +: BIT_WIDTH];
      end
    end
  end

  simultaneous_to_sequential_reg #(
    .DEPTH    (DEPTH),
    .BIT_WIDTH(BIT_WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst_n(in_ctr_Arst_n),
    .clr  (in_ctr_Srst),
    .load (load),
    .en   (en),
    .d    (load_d),
    .head (head)
  );

  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    en        = 1'b0;
    if (in_ctr_Srst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (in_valid && out_ready && SHIFT_LEN > 1) begin
          load      = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
        SHIFT: if (out_ready) begin
          en = 1'b1;
          if (cnt == LAST_CNT) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Async reset gates every output, including the constant out_last of a 1-slice build.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out       = '0;
    out_last  = 1'b0;
    if (in_ctr_Arst_n) begin
      if (state == SHIFT) begin
        out_valid = !in_ctr_Srst;
        out_last  = (cnt == LAST_CNT);
        if (!in_ctr_Srst) out = head;
      end else begin
        in_ready  = out_ready && !in_ctr_Srst;
        out_valid = in_valid && !in_ctr_Srst;
        out_last  = (SHIFT_LEN == 1);
        if (in_valid && !in_ctr_Srst) out = first_slice;
      end
    end
  end

endmodule
